// File: rtl/fifo_read_streamer.sv
// Read-side streamer for synchronous_FIFO: drives r_en and re-presents words as valid/ready. Optional xfer_cnt via FIFO_RD_STREAM_CNT_EN.
// Latency: 2 cycles FIFO-not-empty to m_valid; 1 word/cycle sustained with m_ready held high.
// Backpressure: reads are issued only while occ + inflight < 3, so m_ready never reaches fifo_r_en combinationally.
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  if (BUF_DEPTH != 3) begin : g_bad_depth
    $error("fifo_read_streamer: BUF_DEPTH must be 3");
  end

  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0]            occ;
  logic [1:0]            rd_ptr;
  logic [1:0]            wr_ptr;
  logic                  inflight;
  logic [2:0]            level;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Counting the in-flight read reserves its slot, so a capture always finds room.
  assign level     = {1'b0, occ} + {2'b00, inflight};
  assign fifo_r_en = rst & en & ~fifo_empty & (level < 3'd3);

  assign push    = inflight;
  assign pop     = m_valid & m_ready;
  assign m_valid = (occ != 2'd0);
  assign busy    = (occ != 2'd0) | inflight;

  always_comb begin
    m_data = mem[0];
    case (rd_ptr)
      2'd1:    m_data = mem[1];
      2'd2:    m_data = mem[2];
      default: m_data = mem[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ      <= 2'd0;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      inflight <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
    end else begin
      inflight <= fifo_r_en;
      if (push) begin
        mem[wr_ptr] <= fifo_data_out;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt <= 16'd0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

  overflow_chk: assert property (@(posedge clk) disable iff (!rst)
    (inflight && occ == 2'd3) |-> pop);

endmodule

// File: doc/fifo_read_streamer.md
Name: fifo_read_streamer

Overview:
- Read-side stage directly downstream of synchronous_FIFO.
- Drives the FIFO's r_en and absorbs its one-cycle read latency.
- Re-presents the data as a valid/ready stream with a 3-entry output buffer, sustaining one word per cycle with no combinational path from m_ready to fifo_r_en.
- Sits between the FIFO and any consumer that can apply backpressure.

Parameters:
- DATA_WIDTH, 8, width of FIFO data_out and m_data.
- BUF_DEPTH, 3, output buffer entries; fixed at 3, legal value 3 only.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- en  input  1  1 = fetch from FIFO allowed; 0 = stop issuing new reads.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_r_en=1 is sampled.
- fifo_r_en  output  1  read strobe to FIFO.
- m_valid  output  1  stream output valid.
- m_data  output  DATA_WIDTH  stream output data (buffer head).
- m_ready  input  1  consumer accepts m_data when m_valid&m_ready.
- busy  output  1  1 while buffer occupancy or in-flight read is non-zero.

Behaviour:
- Reset (rst=0, asynchronous):
  - fifo_r_en=0, m_valid=0, m_data=0, busy=0.
  - occ=0, inflight=0, read/write pointers=0.
- State:
  - occ: 0..3, registered buffer occupancy.
  - inflight: 1 bit, registered copy of the previous cycle's fifo_r_en.
- fifo_r_en = en & ~fifo_empty & (occ + inflight < 3). Depends only on registered state, en and fifo_empty; never on m_ready.
- Capture: when inflight=1, fifo_data_out is written into the buffer at the write pointer on that edge.
- Pop: m_valid&m_ready removes the head entry (read pointer advances).
- Push and pop in the same cycle: occ unchanged, both pointers advance.
- Pointers wrap 2->0 (modulo 3).
- m_valid = (occ != 0). m_data = entry at the read pointer, registered/mux output of the buffer.
- Latency: FIFO non-empty at edge N gives fifo_r_en high in cycle N, capture at N+1, m_valid high in cycle N+2. Minimum FIFO-to-output latency is 2 cycles.
- Throughput: with m_ready held at 1 and the FIFO non-empty, steady state is occ=1, inflight=1, with r_en issued every cycle (1 word/cycle).
- Backpressure: with m_ready=0, at most 3 words are pulled (occ + inflight ≤ 3), then fifo_r_en stays 0. No word is ever dropped.
- en deasserted: no new fifo_r_en. An in-flight read is still captured; buffered words still drain.
- fifo_empty=1: fifo_r_en=0 regardless of space.
- m_valid, once high, stays high with m_data stable until accepted.
- Overflow cannot occur by construction. A capture with occ=3 and no pop is an assertion failure.
- busy = (occ != 0) | inflight.
- Reset mid-operation: buffer contents and any in-flight word are discarded; outputs return to reset values immediately. FIFO reset is handled separately by its owner.

Optional Feature:
- Macro: FIFO_RD_STREAM_CNT_EN
- Defined:
  - Adds output port xfer_cnt (16 bits): count of m_valid&m_ready handshakes.
  - Reset to 0; increments by 1 per handshake; wraps 0xFFFF->0x0000.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Single word: FIFO holds 0xA5, en=1, m_ready=1 -> fifo_r_en one cycle; m_valid=1 with m_data=0xA5 two cycles later for exactly one cycle; busy returns to 0.
- Streaming: FIFO preloaded 0x01..0x08, m_ready=1 -> m_data 0x01..0x08 on 8 consecutive cycles, no bubbles, fifo_r_en high 8 consecutive cycles.
- Backpressure: FIFO holds 0x10..0x15, m_ready=0 -> exactly 3 fifo_r_en pulses, m_valid=1 with m_data=0x10 held stable. Then m_ready=1 -> 0x10..0x15 in order, none lost or duplicated.
- Enable gating: en drops the cycle after fifo_r_en issues -> that word still appears on m_data; no further reads. en=1 again -> streaming resumes with the next FIFO word.
- Async reset mid-stream: rst=0 between clock edges with occ=2 -> m_valid, fifo_r_en, busy go 0 immediately. After release with an empty FIFO, outputs stay 0.
- Counter (FIFO_RD_STREAM_CNT_EN defined): 5 handshakes -> xfer_cnt=5. Preset via 65536 handshakes -> wraps to 0.
